pwm_sequence_player: RTL and testbench

- Drives the 10-bit duty-cycle input of a PWM serializer from a small programmable step table.
- Each step is (duty, hold time). The block plays the steps in order, with a fixed off-gap between them.
- Used for the game's light and tone cue patterns: the game FSM loads a pattern, pulses start, and waits for done.
- Sits between the game controller and one PWM serializer instance.

---
 rtl/pwm_sequence_player_pkg.sv | 20 ++
 rtl/pwm_sequence_player_tick_prescaler.sv | 41 ++++
 rtl/pwm_sequence_player.sv | 170 +++++++++++++++++
 tb/tb_pwm_sequence_player.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sequence_player_pkg.sv
// Shared constants and state encoding for the PWM step-sequence player.
package pwm_sequence_player_pkg;

   // Duty-cycle width shared with the PWM serializer.
   localparam int unsigned DUTY_W = 10;

   // Player state encoding.
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_LOAD = 3'd1;
   localparam state_t ST_HOLD = 3'd2;
   localparam state_t ST_GAP  = 3'd3;
   localparam state_t ST_DONE = 3'd4;

   // Counter width for values 0..v-1, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/pwm_sequence_player_tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_CYCLES enabled cycles.
module tick_prescaler
   import pwm_sequence_player_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned   CW   = clog2_min1(TICK_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(TICK_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear has priority, otherwise count up to TERM and restart.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == TERM) ? '0 : cnt_q + ONE;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/pwm_sequence_player.sv
// Plays a programmed (duty, hold) step table into a PWM serializer duty input.
module pwm_sequence_player
   import pwm_sequence_player_pkg::*;
#(
   parameter int unsigned SYS_FREQ_MHZ = 50,
   parameter int unsigned TICK_US      = 1000,
   parameter int unsigned MAX_STEPS    = 16,
   parameter int unsigned GAP_TICKS    = 100,
   parameter int unsigned HOLD_BITS    = 12,
   localparam int unsigned AW          = clog2_min1(MAX_STEPS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [DUTY_W-1:0]    wr_duty,
   input  logic [HOLD_BITS-1:0] wr_hold,
   input  logic [AW:0]          seq_len,
   input  logic                 start,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic [DUTY_W-1:0]    duty_cycle,
   output logic [AW-1:0]        step_idx
);

   localparam int unsigned TICK_CYCLES = SYS_FREQ_MHZ * TICK_US;
   localparam int unsigned GAP_W       = clog2_min1(GAP_TICKS + 1);
   localparam int unsigned CNT_W       = (HOLD_BITS > GAP_W) ? HOLD_BITS : GAP_W;

   localparam logic [AW:0]          LEN_MAX  = (AW+1)'(MAX_STEPS);
   localparam logic [AW:0]          LEN_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]        STEP_ONE = AW'(1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]     GAP_CNT  = CNT_W'(GAP_TICKS);
   localparam logic [HOLD_BITS-1:0] HOLD_MIN = HOLD_BITS'(1);

   // Step table: configuration-time zero, never touched by reset.
   logic [DUTY_W-1:0]    duty_mem [MAX_STEPS] = '{default: '0};
   logic [HOLD_BITS-1:0] hold_mem [MAX_STEPS] = '{default: '0};

   state_t               state_q, state_d;
   logic [AW:0]          len_q, len_d;
   logic [AW-1:0]        step_q, step_d;
   logic [DUTY_W-1:0]    duty_q, duty_d;
   logic [CNT_W-1:0]     ticks_q, ticks_d;
   logic [CNT_W-1:0]     target_q, target_d;

   logic                 timed;
   logic                 tick;
   logic                 phase_done;
   logic                 last_step;
   logic [AW:0]          len_clamped;
   logic [HOLD_BITS-1:0] hold_entry;

   assign timed       = (state_q == ST_HOLD) || (state_q == ST_GAP);
   assign phase_done  = tick && (ticks_q == target_q - CNT_ONE);
   assign last_step   = ({1'b0, step_q} == len_q - LEN_ONE);
   assign len_clamped = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
   assign hold_entry  = (hold_mem[step_q] == '0) ? HOLD_MIN : hold_mem[step_q];

   // Prescaler restarts outside HOLD/GAP and on every phase boundary so each phase is exact.
   tick_prescaler #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .clear_i (!timed || phase_done),
      .en_i    (timed),
      .tick_o  (tick)
   );

   // Table writes, locked out while a sequence is playing.
   always_ff @(posedge clk) begin
      if (wr_en && !busy) begin
         duty_mem[wr_addr] <= wr_duty;
         hold_mem[wr_addr] <= wr_hold;
      end
   end

   // Sequencer next-state logic; abort overrides everything including a same-cycle start.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      step_d   = step_q;
      duty_d   = '0;
      ticks_d  = ticks_q;
      target_d = target_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               step_d  = '0;
               len_d   = len_clamped;
               state_d = (len_clamped == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d  = ST_HOLD;
            duty_d   = duty_mem[step_q];
            target_d = CNT_W'(hold_entry);
            ticks_d  = '0;
         end
         ST_HOLD: begin
            duty_d = duty_q;
            if (phase_done) begin
               duty_d  = '0;
               ticks_d = '0;
               if (last_step) begin
                  state_d = ST_DONE;
               end else if (GAP_TICKS != 0) begin
                  state_d  = ST_GAP;
                  target_d = GAP_CNT;
               end else begin
                  state_d = ST_LOAD;
                  step_d  = step_q + STEP_ONE;
               end
            end else if (tick) begin
               ticks_d = ticks_q + CNT_ONE;
            end
         end
         ST_GAP: begin
            if (phase_done) begin
               ticks_d = '0;
               state_d = ST_LOAD;
               step_d  = step_q + STEP_ONE;
            end else if (tick) begin
               ticks_d = ticks_q + CNT_ONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (abort) begin
         state_d = ST_IDLE;
         duty_d  = '0;
         ticks_d = '0;
         len_d   = len_q;
         step_d  = step_q;
      end
   end

   // Sequencer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         step_q   <= '0;
         duty_q   <= '0;
         ticks_q  <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         step_q   <= step_d;
         duty_q   <= duty_d;
         ticks_q  <= ticks_d;
         target_q <= target_d;
      end
   end

   assign busy       = (state_q == ST_LOAD) || timed;
   assign done       = (state_q == ST_DONE);
   assign duty_cycle = duty_q;
   assign step_idx   = step_q;

endmodule

// File: tb/tb_pwm_sequence_player.sv
// Scoreboard bench: two players (gap 2 ticks / no gap) share stimulus; a model
// expands each start into a per-cycle expected trace that a monitor consumes.
module tb_pwm_sequence_player;

   localparam int unsigned TC = 4;
   localparam int unsigned MS = 4;

   typedef struct {
      logic [9:0] duty;
      logic       busy;
      logic       done;
      logic       chk_step;
      logic [1:0] step;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [9:0] wr_duty = '0;
   logic [11:0] wr_hold = '0;
   logic [2:0] seq_len = '0;
   logic       start = 1'b0;
   logic       abort = 1'b0;

   logic       busy_a, done_a, busy_b, done_b;
   logic [9:0] duty_a, duty_b;
   logic [1:0] step_a, step_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int unsigned mdl_duty [2][MS];
   int unsigned mdl_hold [2][MS];
   int unsigned gap_of [2];

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned cyc    = 0;
   bit          mon_en = 1'b0;

   pwm_sequence_player #(
      .SYS_FREQ_MHZ(1), .TICK_US(4), .MAX_STEPS(4), .GAP_TICKS(2), .HOLD_BITS(12)
   ) dut_gap (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_duty(wr_duty),
      .wr_hold(wr_hold), .seq_len(seq_len), .start(start), .abort(abort),
      .busy(busy_a), .done(done_a), .duty_cycle(duty_a), .step_idx(step_a)
   );

   pwm_sequence_player #(
      .SYS_FREQ_MHZ(1), .TICK_US(4), .MAX_STEPS(4), .GAP_TICKS(0), .HOLD_BITS(12)
   ) dut_nogap (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_duty(wr_duty),
      .wr_hold(wr_hold), .seq_len(seq_len), .start(start), .abort(abort),
      .busy(busy_b), .done(done_b), .duty_cycle(duty_b), .step_idx(step_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input int unsigned d, input bit b, input bit dn,
                               input bit cs, input int unsigned s);
      exp_t e;
      e.duty = 10'(d); e.busy = b; e.done = dn; e.chk_step = cs; e.step = 2'(s);
      return e;
   endfunction

   task automatic push(input int unsigned w, input exp_t e);
      if (w == 0) q_a.push_back(e); else q_b.push_back(e);
   endtask

   // Reference: a start becomes LOAD, hold*TC cycles of duty, gap cycles, ..., DONE.
   task automatic build(input int unsigned w, input int unsigned len);
      int unsigned n, h;
      n = (len > MS) ? MS : len;
      if (n == 0) begin
         push(w, mk(0, 0, 1, 0, 0));
         return;
      end
      for (int unsigned i = 0; i < n; i++) begin
         push(w, mk(0, 1, 0, 1, i));
         h = (mdl_hold[w][i] == 0) ? 1 : mdl_hold[w][i];
         repeat (h * TC) push(w, mk(mdl_duty[w][i], 1, 0, 1, i));
         if (i != n - 1) repeat (gap_of[w] * TC) push(w, mk(0, 1, 0, 1, i));
      end
      push(w, mk(0, 0, 1, 1, n - 1));
   endtask

   task automatic check_dut(input int unsigned w, input logic [9:0] d, input logic b,
                            input logic dn, input logic [1:0] s);
      exp_t e;
      e = mk(0, 0, 0, 0, 0);
      if (w == 0) begin
         if (q_a.size() != 0) e = q_a.pop_front();
      end else begin
         if (q_b.size() != 0) e = q_b.pop_front();
      end
      total++;
      if (d === e.duty && b === e.busy && dn === e.done && (!e.chk_step || s === e.step))
         passed++;
      else
         $display("FAIL trace_dut%0d cyc=%0d got duty=%0d busy=%0b done=%0b step=%0d expected duty=%0d busy=%0b done=%0b step=%0d (step checked=%0b)",
                  w, cyc, d, b, dn, s, e.duty, e.busy, e.done, e.step, e.chk_step);
   endtask

   // Monitor: every cycle each DUT's outputs are checked against the trace front (idle when empty).
   always @(negedge clk) begin
      if (mon_en) begin
         check_dut(0, duty_a, busy_a, done_a, step_a);
         check_dut(1, duty_b, busy_b, done_b, step_b);
      end
   end

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   // A write lands in a DUT only if that DUT is idle in the write cycle.
   task automatic wr(input int unsigned a, input int unsigned d, input int unsigned h);
      bit acc_a, acc_b;
      acc_a = !(q_a.size() != 0 && q_a[0].busy);
      acc_b = !(q_b.size() != 0 && q_b[0].busy);
      wr_en = 1'b1; wr_addr = 2'(a); wr_duty = 10'(d); wr_hold = 12'(h);
      tick1();
      wr_en = 1'b0;
      if (acc_a) begin mdl_duty[0][a] = d; mdl_hold[0][a] = h; end
      if (acc_b) begin mdl_duty[1][a] = d; mdl_hold[1][a] = h; end
   endtask

   task automatic play(input int unsigned len);
      seq_len = 3'(len);
      start = 1'b1;
      tick1();
      start = 1'b0;
      build(0, len);
      build(1, len);
   endtask

   task automatic wait_idle();
      int unsigned k = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && k < 2000) begin
         tick1();
         k++;
      end
      total++;
      if (k < 2000) passed++;
      else $display("FAIL wait_idle timeout got %0d/%0d pending required 0/0", q_a.size(), q_b.size());
      repeat (3) tick1();
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick1();
      abort = 1'b0;
      q_a.delete();
      q_b.delete();
   endtask

   task automatic check_step0(input string nm);
      total++;
      if (step_a === 2'd0 && step_b === 2'd0) passed++;
      else $display("FAIL %s step_idx got %0d/%0d required 0/0", nm, step_a, step_b);
   endtask

   initial begin
      gap_of[0] = 2;
      gap_of[1] = 0;
      for (int unsigned w = 0; w < 2; w++)
         for (int unsigned i = 0; i < MS; i++) begin
            mdl_duty[w][i] = 0;
            mdl_hold[w][i] = 0;
         end

      repeat (3) tick1();
      reset = 1'b0;
      mon_en = 1'b1;
      check_step0("reset_state");

      // Basic playback.
      wr(0, 512, 3); wr(1, 1023, 1); wr(2, 0, 2);
      play(3);
      wait_idle();

      // Zero length.
      play(0);
      wait_idle();

      // hold=0 treated as one tick.
      wr(0, 300, 0);
      play(1);
      wait_idle();

      // Abort in step 0 HOLD, then replay from step 0.
      wr(0, 512, 3);
      play(3);
      repeat (4) tick1();
      do_abort();
      repeat (3) tick1();
      play(3);
      wait_idle();

      // Write lock and ignored restart during playback.
      play(3);
      repeat (2) tick1();
      wr(0, 99, 1);
      start = 1'b1;
      tick1();
      start = 1'b0;
      wait_idle();
      play(1);
      wait_idle();

      // abort+start together in idle: nothing happens.
      seq_len = 3'd3;
      abort = 1'b1; start = 1'b1;
      tick1();
      abort = 1'b0; start = 1'b0;
      repeat (5) tick1();

      // Clamp: seq_len 7 plays four steps.
      wr(3, 700, 1);
      play(7);
      wait_idle();

      // Synchronous reset mid-GAP of step 0 (hold 3 ticks, gap spans T+14..T+21).
      play(7);
      repeat (15) tick1();
      reset = 1'b1;
      tick1();
      reset = 1'b0;
      q_a.delete();
      q_b.delete();
      check_step0("reset_mid_gap");
      repeat (2) tick1();
      play(4);
      wait_idle();

      // Randomized tables and lengths.
      for (int unsigned r = 0; r < 6; r++) begin
         for (int unsigned i = 0; i < MS; i++)
            wr(i, $urandom_range(0, 1023), $urandom_range(0, 3));
         play($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 20)) tick1();
            do_abort();
            repeat (2) tick1();
         end
         wait_idle();
      end

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got running required finished");
      $fatal(1, "timeout");
   end

endmodule
